// File: rtl/x25519_cop_ise_mc_if.sv
// Co-processor port between the RV64 core and the X25519 multiply-add unit.
// The core drives the master side; the co-processor drives the slave side.
interface x25519_cop_ise_mc_if #(
  parameter int XLEN = 64
) ();
  logic            cop_valid;
  logic            cop_rdywr;
  logic            cop_ready;
  logic            cop_wait;
  logic            cop_wr;
  logic [31:0]     cop_insn;
  logic [XLEN-1:0] cop_rs1;
  logic [XLEN-1:0] cop_rs2;
  logic [XLEN-1:0] cop_rs3;
  logic [XLEN-1:0] cop_rd;

  modport master (
    output cop_valid, cop_rdywr, cop_insn, cop_rs1, cop_rs2, cop_rs3,
    input  cop_ready, cop_wait, cop_wr, cop_rd
  );

  modport slave (
    input  cop_valid, cop_rdywr, cop_insn, cop_rs1, cop_rs2, cop_rs3,
    output cop_ready, cop_wait, cop_wr, cop_rd
  );
endinterface

// File: rtl/x25519_cop_ise_mc.sv
// Iterative maddlu/maddhu unit: acc = rs1*rs2 + rs3, MUL_W bits of rs2 per cycle,
// with a one-entry operand/result cache so the paired lo/hi instruction is free.
module x25519_cop_ise_mc #(
  parameter logic [1:0] ISE_V    = 2'b11,
  parameter int         XLEN     = 64,
  parameter int         MUL_W    = 16,
  parameter bit         CACHE_EN = 1'b1
) (
  input logic                cop_clk,
  input logic                cop_rst,
  x25519_cop_ise_mc_if.slave cop
);
  localparam int N  = XLEN / MUL_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(2 * XLEN);
  localparam int LW = $clog2(MUL_W);
  localparam int PW = XLEN + MUL_W;

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t              state, state_nxt;
  logic [XLEN-1:0]     rs1_q, rs2_q, rs3_q;
  logic [XLEN-1:0]     c_rs1, c_rs2, c_rs3;
  logic [2*XLEN-1:0]   acc, acc_nxt, c_res;
  logic [CW-1:0]       cnt;
  logic                op_hi, cache_vld;
  logic                hit, cache_hit, accept, last;
  logic [SW-1:0]       shamt;
  logic [MUL_W-1:0]    digit;
  logic [PW-1:0]       pp;
  logic                unused_insn;

  // funct[1]=insn[26] selects the undecoded pair, funct[0]=insn[25] picks lo/hi.
  assign hit = ISE_V[1] && (cop.cop_insn[6:0] == 7'b0101011) && !cop.cop_insn[26];
  assign unused_insn = ^{cop.cop_insn[31:27], cop.cop_insn[24:7]};

  assign cache_hit = CACHE_EN && cache_vld && (cop.cop_rs1 == c_rs1) &&
                     (cop.cop_rs2 == c_rs2) && (cop.cop_rs3 == c_rs3);
  assign accept    = (state == IDLE) && cop.cop_valid && hit;
  assign last      = (cnt == CW'(N - 1));

  // One MUL_W-bit digit of rs2 per cycle, partial product aligned to its weight.
  assign shamt   = SW'(cnt) << LW;
  assign digit   = MUL_W'(rs2_q >> shamt);
  assign pp      = PW'(rs1_q) * PW'(digit);
  assign acc_nxt = acc + ((2 * XLEN)'(pp) << shamt);

  always_ff @(posedge cop_clk or posedge cop_rst) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (cop_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = cache_hit ? RESP : MUL;
      MUL:     if (last) state_nxt = RESP;
      RESP:    if (cop.cop_rdywr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cop_clk or posedge cop_rst) begin
    if (cop_rst) begin
      acc       <= '0;
      cnt       <= '0;
      op_hi     <= 1'b0;
      cache_vld <= 1'b0;
    end else if (accept) begin
      op_hi <= cop.cop_insn[25];
      cnt   <= '0;
      acc   <= cache_hit ? c_res : {{XLEN{1'b0}}, cop.cop_rs3};
    end else if (state == MUL) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (last && CACHE_EN) cache_vld <= 1'b1;
    end
  end

  // NOTE: operand copies and cache payload carry no reset; the valid bit and
  // the FSM guarantee they are written before being used.
  always_ff @(posedge cop_clk) begin
    if (accept && !cache_hit) begin
      rs1_q <= cop.cop_rs1;
      rs2_q <= cop.cop_rs2;
      rs3_q <= cop.cop_rs3;
    end
    if ((state == MUL) && last) begin
      c_rs1 <= rs1_q;
      c_rs2 <= rs2_q;
      c_rs3 <= rs3_q;
      c_res <= acc_nxt;
    end
  end

  assign cop.cop_wait  = (state == MUL);
  assign cop.cop_wr    = (state == RESP);
  assign cop.cop_rd    = (state != RESP) ? '0 :
                         op_hi ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
  assign cop.cop_ready = ~(cop.cop_wr & ~cop.cop_rdywr);
endmodule

// File: tb/tb_x25519_cop_ise_mc.sv
// Scoreboard bench: five instances (default, ISE_V=01, MUL_W 8/32/64 uncached)
// share clock and reset; a monitor pops expected results on each write-back.
module tb_x25519_cop_ise_mc;
  localparam int NI = 5;
  localparam logic [1:0] ISE_P [NI] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b11};
  localparam int         MW_P  [NI] = '{16, 16, 8, 32, 64};
  localparam bit         CE_P  [NI] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [6:0] OPC   = 7'b0101011;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk, rst;
  logic        valid [NI];
  logic        rdywr [NI];
  logic        ready [NI];
  logic        wt    [NI];
  logic        wr    [NI];
  logic [31:0] insn  [NI];
  logic [63:0] rs1   [NI];
  logic [63:0] rs2   [NI];
  logic [63:0] rs3   [NI];
  logic [63:0] rd    [NI];

  logic [63:0] exp_q [NI][$];
  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    x25519_cop_ise_mc_if #(.XLEN(64)) bus ();
    assign bus.cop_valid = valid[g];
    assign bus.cop_rdywr = rdywr[g];
    assign bus.cop_insn  = insn[g];
    assign bus.cop_rs1   = rs1[g];
    assign bus.cop_rs2   = rs2[g];
    assign bus.cop_rs3   = rs3[g];
    assign ready[g]      = bus.cop_ready;
    assign wt[g]         = bus.cop_wait;
    assign wr[g]         = bus.cop_wr;
    assign rd[g]         = bus.cop_rd;

    x25519_cop_ise_mc #(
      .ISE_V(ISE_P[g]), .XLEN(64), .MUL_W(MW_P[g]), .CACHE_EN(CE_P[g])
    ) u_dut (
      .cop_clk(clk),
      .cop_rst(rst),
      .cop    (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] funct, input logic [6:0] opc);
    return {funct, 18'd0, opc};
  endfunction

  // 128-bit reference for rs1*rs2 + rs3.
  function automatic logic [63:0] madd(input logic [63:0] a, b, c, input bit hi);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b} + {64'd0, c};
    return hi ? p[127:64] : p[63:0];
  endfunction

  // Monitor: exclusivity of wait/wr every cycle, result compare on write-back.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NI; k++) begin
        check($sformatf("wait_wr_excl[%0d]", k), 64'(wt[k] & wr[k]), 64'd0);
        if (wr[k] && rdywr[k]) begin
          if (exp_q[k].size() == 0) check($sformatf("unexpected_wr[%0d]", k), 64'd1, 64'd0);
          else check($sformatf("rd[%0d]", k), rd[k], exp_q[k].pop_front());
        end
      end
    end
  end

  task automatic issue(input int k, input logic [6:0] funct, input logic [63:0] a, b, c,
                       input logic [63:0] expv, input int lat, input int stall);
    int i, nwait;
    logic [63:0] held;
    exp_q[k].push_back(expv);
    @(posedge clk); #1;
    valid[k] = 1'b1; insn[k] = mk(funct, OPC);
    rs1[k] = a; rs2[k] = b; rs3[k] = c;
    rdywr[k] = (stall == 0);
    @(posedge clk);
    i = 1; nwait = 0;
    @(negedge clk);
    while (!wr[k] && i < 200) begin
      if (wt[k]) nwait++;
      @(negedge clk);
      i++;
    end
    check($sformatf("latency[%0d]", k), 64'(i), 64'(lat));
    check($sformatf("wait_cycles[%0d]", k), 64'(nwait), 64'(lat - 1));
    if (!wr[k]) begin
      valid[k] = 1'b0; rdywr[k] = 1'b1;
      return;
    end
    held = rd[k];
    for (int j = 0; j < stall; j++) begin
      check("stall_wr", 64'(wr[k]), 64'd1);
      check("stall_ready", 64'(ready[k]), 64'd0);
      check("stall_rd", rd[k], held);
      @(posedge clk); #1;
      if (j == stall - 1) rdywr[k] = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    valid[k] = 1'b0;
    @(negedge clk);
    check($sformatf("idle_after_wb[%0d]", k), 64'(wr[k] | wt[k]), 64'd0);
  endtask

  task automatic no_response(input int k, input logic [31:0] ins);
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    valid[k] = 1'b1; insn[k] = ins; rs1[k] = 64'd3; rs2[k] = 64'd5; rs3[k] = 64'd7;
    repeat (20) begin
      @(negedge clk);
      seen = seen | wr[k] | wt[k];
    end
    check($sformatf("no_response[%0d]", k), 64'(seen), 64'd0);
    @(posedge clk); #1;
    valid[k] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] va [3];
    logic [63:0] vb [3];
    logic [63:0] vc [3];
    logic [63:0] ya, yb, yc;
    va = '{64'h0123_4567_89AB_CDEF, ONES, 64'hDEAD_BEEF_0000_0001};
    vb = '{64'hFEDC_BA98_7654_3210, 64'h0000_0000_0000_0002, 64'h8000_0000_0000_0000};
    vc = '{64'h1111_2222_3333_4444, ONES, 64'h0000_0000_0000_0005};
    ya = 64'h0F0F_0F0F_F0F0_F0F0; yb = 64'h1234_5678_9ABC_DEF0; yc = 64'h0000_0000_0000_00FF;

    for (int k = 0; k < NI; k++) begin
      valid[k] = 1'b0; rdywr[k] = 1'b1; insn[k] = '0;
      rs1[k] = '0; rs2[k] = '0; rs3[k] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_wr", 64'(wr[0]), 64'd0);
    check("reset_wait", 64'(wt[0]), 64'd0);
    check("reset_rd", rd[0], 64'd0);
    check("reset_ready", 64'(ready[0]), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Basic, extreme operands, cache hit, write-back stall.
    issue(0, 7'd0, 64'd3, 64'd5, 64'd7, 64'd22, 5, 0);
    issue(0, 7'd1, 64'd4, 64'd6, 64'd8, 64'd0, 5, 0);
    issue(0, 7'd0, ONES, ONES, ONES, 64'd0, 5, 0);
    issue(0, 7'd1, ONES, ONES, ONES, ONES, 1, 0);
    issue(0, 7'd0, ONES, ONES, ONES, 64'd0, 1, 2);
    issue(0, 7'd0, 64'd3, 64'd5, 64'd7, 64'd22, 5, 3);

    // Reset in the second MUL cycle: outputs drop at once, instruction dropped.
    @(posedge clk); #1;
    valid[0] = 1'b1; insn[0] = mk(7'd0, OPC); rs1[0] = ya; rs2[0] = yb; rs3[0] = yc;
    @(posedge clk);
    @(posedge clk); #2;
    check("mid_mul_wait", 64'(wt[0]), 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_wait", 64'(wt[0]), 64'd0);
    check("async_rst_wr", 64'(wr[0]), 64'd0);
    check("async_rst_rd", rd[0], 64'd0);
    valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    issue(0, 7'd0, ya, yb, yc, madd(ya, yb, yc, 1'b0), 5, 0);
    issue(0, 7'd0, 64'd3, 64'd5, 64'd7, 64'd22, 5, 0);
    issue(0, 7'd1, 64'd3, 64'd5, 64'd7, 64'd0, 1, 0);

    // Non-decoded instructions and a disabled ISE.
    no_response(0, mk(7'd0, 7'b0001011));
    no_response(0, mk(7'd2, OPC));
    no_response(0, mk(7'd3, OPC));
    no_response(1, mk(7'd0, OPC));

    // Multiplier width sweep, cache disabled: both halves recomputed each time.
    for (int k = 2; k < NI; k++) begin
      for (int v = 0; v < 3; v++) begin
        issue(k, 7'd0, va[v], vb[v], vc[v], madd(va[v], vb[v], vc[v], 1'b0), 64 / MW_P[k] + 1, 0);
        issue(k, 7'd1, va[v], vb[v], vc[v], madd(va[v], vb[v], vc[v], 1'b1), 64 / MW_P[k] + 1, 0);
      end
    end

    repeat (3) @(posedge clk);
    for (int k = 0; k < NI; k++)
      check($sformatf("scoreboard_drained[%0d]", k), 64'(exp_q[k].size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
